axi4s_fifo: RTL and testbench

Parametrised synchronous AXI4-Stream FIFO that buffers beats between an upstream stream master and a downstream stream slave in one clock domain. Carries TDATA, TKEEP, TLAST and TUSER; depth, data width and user width are generic. It is the standard elastic buffer placed between stream producers (video, DMA, packet engines) and consumers. An optional compile-time packet mode provides store-and-forward behaviour.

---
 rtl/axi4s_fifo.sv | 138 +++++++++++++
 tb/tb_axi4s_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4s_fifo.sv
// Purpose: synchronous AXI4-Stream elastic buffer carrying TDATA/TKEEP/TLAST/TUSER.
// Latency: a beat pushed into an empty FIFO is presented on M_* the next cycle.
// Backpressure: S_TREADY drops when DEPTH beats are held; M_TREADY low holds the head stable.
//
// Ports: ACLK/ARESET (async, active-high); S_* upstream slave side; M_* downstream
// master side; LEVEL = beats stored; PKT_CNT = stored beats carrying TLAST.
// Optional macro AXI4S_FIFO_PACKET_MODE_EN: store-and-forward, M_TVALID is held off
// until a complete packet is stored (or the FIFO fills, which forces cut-through).
module axi4s_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int LVL_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  S_TVALID,
  output logic                  S_TREADY,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic [KEEP_WIDTH-1:0] S_TKEEP,
  input  logic                  S_TLAST,
  input  logic [USER_WIDTH-1:0] S_TUSER,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic [KEEP_WIDTH-1:0] M_TKEEP,
  output logic                  M_TLAST,
  output logic [USER_WIDTH-1:0] M_TUSER,
  output logic [LVL_WIDTH-1:0]  LEVEL,
  output logic [LVL_WIDTH-1:0]  PKT_CNT
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  beat_t          mem [DEPTH];
  beat_t          s_beat;
  beat_t          head_q;
  beat_t          head_nxt;
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [AW:0]    wr_ptr_nxt;
  logic [AW:0]    rd_ptr_nxt;
  logic [LVL_WIDTH-1:0] pkt_cnt;
  logic           up_q;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  assign s_beat = {S_TDATA, S_TKEEP, S_TLAST, S_TUSER};

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // up_q keeps S_TREADY low until the first edge after reset is released.
  assign S_TREADY = up_q & ~full;

`ifdef AXI4S_FIFO_PACKET_MODE_EN
  // cut_q: FIFO filled with no TLAST stored; stream the oversized packet through
  // until its TLAST leaves, otherwise it could never be released.
  logic cut_q;
  assign M_TVALID = ((pkt_cnt != '0) | full | cut_q) & ~empty;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cut_q <= 1'b0;
    end else if (pop && head_q.last) begin
      cut_q <= 1'b0;
    end else if (full && (pkt_cnt == '0)) begin
      cut_q <= 1'b1;
    end
  end
`else
  assign M_TVALID = ~empty;
`endif

  assign push = S_TVALID & S_TREADY;
  assign pop  = M_TVALID & M_TREADY;

  assign wr_ptr_nxt = wr_ptr + LVL_WIDTH'(push);
  assign rd_ptr_nxt = rd_ptr + LVL_WIDTH'(pop);

  // Registered head: the beat at the next read pointer. If that slot is the one
  // being written this edge (FIFO draining to empty while pushing), forward the
  // incoming beat. When the FIFO goes empty the last payload is held.
  always_comb begin
    head_nxt = head_q;
    if (wr_ptr_nxt != rd_ptr_nxt) begin
      if (rd_ptr_nxt == wr_ptr) begin
        head_nxt = s_beat;
      end else begin
        head_nxt = mem[rd_ptr_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s_beat;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      up_q    <= 1'b0;
      head_q  <= '0;
      pkt_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      up_q   <= 1'b1;
      head_q <= head_nxt;
      case ({push && S_TLAST, pop && head_q.last})
        2'b10:   pkt_cnt <= pkt_cnt + LVL_WIDTH'(1);
        2'b01:   pkt_cnt <= pkt_cnt - LVL_WIDTH'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  assign M_TDATA = head_q.data;
  assign M_TKEEP = head_q.keep;
  assign M_TLAST = head_q.last;
  assign M_TUSER = head_q.user;
  assign LEVEL   = wr_ptr - rd_ptr;
  assign PKT_CNT = pkt_cnt;

endmodule

// File: tb/tb_axi4s_fifo.sv
// Testbench for axi4s_fifo: directed stimulus plus a queue-based reference model
// checked every cycle on the falling edge, with literal expectations per scenario.
module tb_axi4s_fifo;

  localparam int DW = 16;
  localparam int UW = 1;
  localparam int KW = DW / 8;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          S_TVALID;
  logic          S_TREADY;
  logic [DW-1:0] S_TDATA;
  logic [KW-1:0] S_TKEEP;
  logic          S_TLAST;
  logic [UW-1:0] S_TUSER;
  logic          M_TVALID;
  logic          M_TREADY;
  logic [DW-1:0] M_TDATA;
  logic [KW-1:0] M_TKEEP;
  logic          M_TLAST;
  logic [UW-1:0] M_TUSER;
  logic [LW-1:0] LEVEL;
  logic [LW-1:0] PKT_CNT;

  axi4s_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
    .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST), .S_TUSER(S_TUSER),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
    .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST), .M_TUSER(M_TUSER),
    .LEVEL(LEVEL), .PKT_CNT(PKT_CNT)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } mbeat_t;

  mbeat_t q[$];
  bit     m_up  = 0;
  bit     m_cut = 0;

  function automatic int nlast();
    int n = 0;
    foreach (q[i]) if (q[i].l) n++;
    return n;
  endfunction

  // Inputs change 1 time unit after a rising edge, so the values seen here are
  // the ones the next rising edge acts on: check, then advance the model.
  always @(negedge ACLK) begin
    bit     exp_rdy, exp_vld, mpush, mpop;
    mbeat_t b, tmp;
    if (ARESET) begin
      q.delete();
      m_up  = 0;
      m_cut = 0;
      chk("rst_s_tready", S_TREADY, 0);
      chk("rst_m_tvalid", M_TVALID, 0);
      chk("rst_level", LEVEL, 0);
      chk("rst_pkt_cnt", PKT_CNT, 0);
    end else begin
      exp_rdy = m_up && (q.size() < DEPTH);
`ifdef AXI4S_FIFO_PACKET_MODE_EN
      exp_vld = (q.size() != 0) && (nlast() > 0 || q.size() == DEPTH || m_cut);
`else
      exp_vld = (q.size() != 0);
`endif
      chk("s_tready", S_TREADY, exp_rdy);
      chk("m_tvalid", M_TVALID, exp_vld);
      chk("level", LEVEL, q.size());
      chk("pkt_cnt", PKT_CNT, nlast());
      if (exp_vld) begin
        chk("m_tdata", M_TDATA, q[0].d);
        chk("m_tkeep", M_TKEEP, q[0].k);
        chk("m_tlast", M_TLAST, q[0].l);
        chk("m_tuser", M_TUSER, q[0].u);
      end
      mpush = S_TVALID && exp_rdy;
      mpop  = M_TREADY && exp_vld;
      if (q.size() == DEPTH && nlast() == 0) m_cut = 1;
      if (mpop) begin
        tmp = q.pop_front();
        if (tmp.l) m_cut = 0;
      end
      if (mpush) begin
        b.d = S_TDATA; b.k = S_TKEEP; b.l = S_TLAST; b.u = S_TUSER;
        q.push_back(b);
      end
      m_up = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    S_TVALID = 1'b0;
    M_TREADY = 1'b1;
    while (LEVEL != 0 && n < 200) begin
      step();
      n++;
    end
    chk(name, LEVEL, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int pushed, cyc, n;
    bit acc;
    ARESET = 1'b1; S_TVALID = 1'b0; S_TDATA = '0; S_TKEEP = '1;
    S_TLAST = 1'b0; S_TUSER = '0; M_TREADY = 1'b0;
    repeat (2) step();
    chk("reset_tready", S_TREADY, 0);
    chk("reset_tdata", M_TDATA, 0);
    ARESET = 1'b0;
    #1;
    chk("tready_before_edge", S_TREADY, 0);
    step();
    chk("tready_after_edge", S_TREADY, 1);

    // Four beats held with M_TREADY low, then drained in order.
    S_TVALID = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      S_TDATA = DW'(i);
      S_TLAST = (i == 4);
      step();
    end
    S_TVALID = 1'b0; S_TLAST = 1'b0;
    chk("t1_level", LEVEL, 4);
    chk("t1_valid", M_TVALID, 1);
    chk("t1_head", M_TDATA, 16'h0001);
    chk("t1_pkt_cnt", PKT_CNT, 1);
    M_TREADY = 1'b1;
    repeat (4) step();
    chk("t1_empty_level", LEVEL, 0);
    chk("t1_empty_valid", M_TVALID, 0);
    M_TREADY = 1'b0;

    // Fill to DEPTH; 17th beat waits until one pop frees a slot.
    S_TVALID = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      S_TDATA = DW'(16'h0100 + i);
      step();
    end
    S_TDATA = 16'h0110;
    chk("full_tready", S_TREADY, 0);
    chk("full_level", LEVEL, 16);
    step();
    chk("full_hold_level", LEVEL, 16);
    M_TREADY = 1'b1;
    step();
    M_TREADY = 1'b0;
    chk("after_pop_tready", S_TREADY, 1);
    chk("after_pop_level", LEVEL, 15);
    step();
    chk("beat17_level", LEVEL, 16);
    drain("fill_drain");

    // Sustained streaming across pointer wrap: level settles at 1.
    S_TVALID = 1'b1; M_TREADY = 1'b1; S_TLAST = 1'b1;
    for (int i = 0; i < 100; i++) begin
      S_TDATA = DW'(16'h2000 + i);
      step();
      chk("stream_level", LEVEL, 1);
    end
    S_TLAST = 1'b0;
    drain("stream_drain");

    // Random valid/ready with random sideband; the model checks every cycle.
    pushed = 0; cyc = 0; acc = 0; S_TVALID = 1'b0;
    while (pushed < 1000 && cyc < 10000) begin
      if (!S_TVALID || acc) begin
        S_TVALID = 1'($urandom_range(0, 1));
        S_TDATA  = DW'($urandom);
        S_TKEEP  = KW'($urandom);
        S_TUSER  = UW'($urandom);
        S_TLAST  = ($urandom_range(0, 3) == 0);
      end
      M_TREADY = 1'($urandom_range(0, 1));
      #1;
      acc = S_TVALID && S_TREADY;
      step();
      if (acc) pushed++;
      cyc++;
    end
    chk("random_beats_pushed", pushed, 1000);
    drain("random_drain");
    S_TKEEP = '1; S_TUSER = '0; S_TLAST = 1'b0;

    // Reset mid-packet with five beats stored.
    M_TREADY = 1'b0; S_TVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      S_TDATA = DW'(16'h0A00 + i);
      step();
    end
    S_TVALID = 1'b0;
    chk("pre_reset_level", LEVEL, 5);
    ARESET = 1'b1;
    #1;
    chk("async_rst_valid", M_TVALID, 0);
    chk("async_rst_level", LEVEL, 0);
    chk("async_rst_tready", S_TREADY, 0);
    chk("async_rst_tdata", M_TDATA, 0);
    step();
    ARESET = 1'b0;
    step();
    chk("post_rst_tready", S_TREADY, 1);
    S_TVALID = 1'b1; S_TDATA = 16'hBEEF; S_TLAST = 1'b1;
    step();
    S_TVALID = 1'b0; S_TLAST = 1'b0;
    chk("beef_valid", M_TVALID, 1);
    chk("beef_data", M_TDATA, 16'hBEEF);
    M_TREADY = 1'b1;
    step();
    chk("beef_gone", M_TVALID, 0);

`ifdef AXI4S_FIFO_PACKET_MODE_EN
    // Store-and-forward: nothing released until the TLAST beat is stored.
    S_TVALID = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      S_TDATA = DW'(16'h3000 + i);
      S_TLAST = (i == 3);
      step();
      chk("pkt3_valid", M_TVALID, (i == 3));
    end
    chk("pkt3_head", M_TDATA, 16'h3001);
    drain("pkt3_drain");

    // Packet longer than DEPTH must be released at full and complete.
    pushed = 0; n = 0; S_TVALID = 1'b1; M_TREADY = 1'b1;
    while (pushed < 20 && n < 500) begin
      S_TDATA = DW'(16'h4000 + pushed);
      S_TLAST = (pushed == 19);
      #1;
      acc = S_TREADY;
      step();
      if (acc) pushed++;
      n++;
    end
    chk("long_pkt_pushed", pushed, 20);
    S_TLAST = 1'b0;
    drain("long_pkt_drain");
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
